// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory port, redirect from execute, decode handshake.
// master = fetch unit side, slave = environment (memory/execute/decode) side.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INSTR_W = 37
);
  logic               fetch_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [15:0]        fetch_count;

  modport master (
    input  fetch_en,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready,
    output imem_addr,
    output out_valid,
    output out_instr,
    output out_pc,
    output fetch_count
  );

  modport slave (
    output fetch_en,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    output out_ready,
    input  imem_addr,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the zero-latency instruction memory and queues
// {instr, pc} pairs in a small FIFO towards decode. Redirects flush and reload the PC.
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       INSTR_W  = 37,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        fetch_count_q, fetch_count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] head;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A redirect kills both sides of the FIFO in the same cycle.
  assign pop  = ~empty & bus.out_ready & ~bus.redirect_valid;
  // Full with a simultaneous pop still accepts a new entry, so streaming has no bubble.
  assign push = bus.fetch_en & ~bus.redirect_valid & (~full | pop);

  always_comb begin
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
        fetch_count_d = fetch_count_q + 16'd1;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.imem_instr, pc_q};
    end
  end

  assign head                        = mem_q[rd_ptr_q];
  assign bus.imem_addr               = pc_q;
  assign bus.out_valid               = ~empty;
  assign {bus.out_instr, bus.out_pc} = empty ? '0 : head;
  assign bus.fetch_count             = fetch_count_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage sitting directly upstream of the 1024 x 37-bit instruction memory. It owns the program counter, drives the memory address and captures the combinational read data. Fetched {pc, instruction} pairs are pushed into a small FIFO that feeds decode through a valid/ready handshake. Execute can redirect fetch (branch/jump) and flush the FIFO.

Parameters:
ADDR_W, 10, instruction address width (word addressed, 1024 locations)
INSTR_W, 37, instruction width
DEPTH, 4, fetch FIFO entries (power of two, >= 2)
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  1 = fetching allowed; 0 = PC frozen, no pushes
imem_addr  output  ADDR_W  address to instruction memory (= pc, combinational)
imem_instr  input  INSTR_W  instruction memory read data, valid same cycle as imem_addr
redirect_valid  input  1  1-cycle pulse: flush FIFO and load redirect_pc
redirect_pc  input  ADDR_W  new fetch address
out_valid  output  1  FIFO non-empty
out_ready  input  1  decode accepts head entry
out_instr  output  INSTR_W  head-entry instruction
out_pc  output  ADDR_W  head-entry address
fetch_count  output  16  instructions delivered (popped) since reset, wraps

Behaviour:
- State: pc (ADDR_W), FIFO storage DEPTH x (INSTR_W+ADDR_W), rd/wr pointers, occupancy count (0..DEPTH), fetch_count.
- Reset (async, rst_n=0): pc=RESET_PC, pointers=0, count=0, fetch_count=0; out_valid=0, out_instr=0, out_pc=0 (outputs forced to 0 whenever empty). Storage contents need not be reset.
- imem_addr = pc at all times (combinational, no added latency); memory has zero-cycle read, so fetch latency PC->FIFO is 1 clock; FIFO->decode visible the cycle after push.
- pop = out_valid & out_ready & ~redirect_valid.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop). Full FIFO with simultaneous pop still pushes (no bubble).
- On push: entry {imem_instr, pc} written at wr ptr, wr ptr++, pc <= pc+1 mod 2^ADDR_W (1023 -> 0 wrap, no flag).
- On pop: rd ptr++, fetch_count++ (wraps 65535 -> 0).
- count update: +1 on push only, -1 on pop only, unchanged on both/neither.
- Redirect (highest priority): next cycle count=0, rd=wr=0, pc=redirect_pc; no push, no pop, fetch_count unchanged that cycle; head shown during the redirect cycle is discarded even if out_ready=1. Fetch resumes from redirect_pc the following cycle if fetch_en=1.
- Back-to-back redirects: last one wins; each flushes.
- fetch_en=0: pc and pushes frozen; pops continue draining FIFO.
- out_instr/out_pc stable while out_valid=1 and out_ready=0 (no change except by redirect or reset).
- Reset asserted mid-operation: all state cleared immediately regardless of clock.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, memory[i]=i+100 -> out_valid rises cycle 2; outputs (pc,instr) = (0,100),(1,101),(2,102)... one per cycle; fetch_count increments each cycle.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 pushes, pc stops at 4, head stays (0,100); release out_ready -> (0..3) then (4,104) with no gap or duplicate.
- Full FIFO, out_ready=1 held -> push and pop same cycle, count stays 4, continuous stream, no bubble.
- Redirect pulse redirect_pc=500 while FIFO holds 3 entries and out_ready=1 -> next cycle out_valid=0, imem_addr=500; next delivered entry (500, memory[500]); flushed entries never appear, fetch_count not incremented on redirect cycle.
- Start redirect_pc=1022, stream -> pc sequence 1022, 1023, 0, 1 delivered in order.
- fetch_en=0 with 2 entries queued -> both drain, imem_addr frozen; rst_n pulsed low mid-stream -> out_valid=0, imem_addr=0, fetch_count=0 immediately, asynchronously.
